dmem_access_unit: RTL

//  MEM-stage load/store sequencer between the EX/MEM pipeline register and data memory.

---
 rtl/dmem_access_unit_if.sv | 22 ++
 rtl/dmem_access_unit.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/dmem_access_unit_if.sv
// Data-memory bus between the MEM-stage access unit (master) and data memory (slave).
interface dmem_access_unit_if #(
    parameter int ADDR_WIDTH = 32
);
    logic                  dmem_read;
    logic                  dmem_write;
    logic [ADDR_WIDTH-1:0] dmem_addr;
    logic [31:0]           dmem_wdata;
    logic [3:0]            dmem_byteen;
    logic [31:0]           dmem_rdata;
    logic                  dmem_busywait;

    modport master (
        output dmem_read, dmem_write, dmem_addr, dmem_wdata, dmem_byteen,
        input  dmem_rdata, dmem_busywait
    );

    modport slave (
        input  dmem_read, dmem_write, dmem_addr, dmem_wdata, dmem_byteen,
        output dmem_rdata, dmem_busywait
    );
endinterface

// File: rtl/dmem_access_unit.sv
// MEM-stage load/store sequencer: issues byte/half/word accesses, stalls across busywait.
// Optional macro MISALIGN_TRAP_EN: misaligned H/W accesses trap instead of being truncated.
//
// state  | meaning
// IDLE   | waiting for a load/store from EX/MEM
// ACCESS | strobe held on the memory bus until busywait drops or timeout
// DONE   | result/flags visible for one cycle, pipeline advances
module dmem_access_unit #(
    parameter int ADDR_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  mem_read,
    input  logic                  mem_write,
    input  logic [2:0]            func3,
    input  logic [ADDR_WIDTH-1:0] address,
    input  logic [31:0]           write_data,
    output logic [31:0]           load_data,
    output logic                  stall,
    output logic                  access_err,
    output logic                  misaligned,
    dmem_access_unit_if.master    dmem
);

    localparam int               CNT_W      = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX    = CNT_W'(TIMEOUT_CYCLES);
    localparam bit               TIMEOUT_EN = (TIMEOUT_CYCLES > 0);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t state, state_nx;

    logic                  req;
    logic                  req_mis;
    logic [3:0]            req_be;
    logic [31:0]           req_wdata;

    logic                  is_load_q;
    logic [2:0]            func3_q;
    logic [1:0]            lo_q;
    logic                  err_q;
    logic                  mis_q;
    logic [CNT_W-1:0]      cnt_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [31:0]           wdata_q;
    logic [3:0]            be_q;

    logic                  complete;
    logic                  timeout_hit;
    logic [7:0]            byte_sel;
    logic [15:0]           half_sel;
    logic                  sign_ext;
    logic [31:0]           load_ext;

    assign req = mem_read | mem_write;

    // func3[1:0]: 00 byte, 01 half, anything else is a word access
    always_comb begin
        req_be    = 4'b1111;
        req_wdata = write_data;
        case (func3[1:0])
            2'b00: begin
                req_be    = 4'b0001 << address[1:0];
                req_wdata = {4{write_data[7:0]}};
            end
            2'b01: begin
                req_be    = 4'b0011 << {address[1], 1'b0};
                req_wdata = {2{write_data[15:0]}};
            end
            default: ;
        endcase
    end

`ifdef MISALIGN_TRAP_EN
    assign req_mis = ((func3[1:0] == 2'b01) && address[0]) ||
                     (func3[1] && (address[1:0] != 2'b00));
`else
    assign req_mis = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx    = state;
        stall       = 1'b0;
        complete    = 1'b0;
        timeout_hit = 1'b0;
        case (state)
            IDLE: begin
                if (req) begin
                    stall    = 1'b1;
                    state_nx = req_mis ? DONE : ACCESS;
                end
            end
            ACCESS: begin
                stall = 1'b1;
                if (!dmem.dmem_busywait) begin
                    complete = 1'b1;
                    state_nx = DONE;
                end else if (TIMEOUT_EN && (cnt_q == CNT_MAX)) begin
                    timeout_hit = 1'b1;
                    state_nx    = DONE;
                end
            end
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // lane extraction uses the offset captured at request time
    always_comb begin
        byte_sel = dmem.dmem_rdata[7:0];
        case (lo_q)
            2'd1:    byte_sel = dmem.dmem_rdata[15:8];
            2'd2:    byte_sel = dmem.dmem_rdata[23:16];
            2'd3:    byte_sel = dmem.dmem_rdata[31:24];
            default: byte_sel = dmem.dmem_rdata[7:0];
        endcase
        half_sel = lo_q[1] ? dmem.dmem_rdata[31:16] : dmem.dmem_rdata[15:0];
        sign_ext = ~func3_q[2];
        case (func3_q[1:0])
            2'b00:   load_ext = {{24{sign_ext & byte_sel[7]}}, byte_sel};
            2'b01:   load_ext = {{16{sign_ext & half_sel[15]}}, half_sel};
            default: load_ext = dmem.dmem_rdata;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            is_load_q <= 1'b0;
            func3_q   <= 3'b000;
            lo_q      <= 2'b00;
            err_q     <= 1'b0;
            mis_q     <= 1'b0;
            cnt_q     <= '0;
            addr_q    <= '0;
            wdata_q   <= '0;
            be_q      <= 4'b0000;
            load_data <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req) begin
                        is_load_q <= mem_read;
                        func3_q   <= func3;
                        lo_q      <= address[1:0];
                        mis_q     <= req_mis;
                        err_q     <= 1'b0;
                        cnt_q     <= '0;
                        if (!req_mis) begin
                            addr_q  <= {address[ADDR_WIDTH-1:2], 2'b00};
                            wdata_q <= req_wdata;
                            be_q    <= req_be;
                        end
                    end
                end
                ACCESS: begin
                    if (complete) begin
                        if (is_load_q) begin
                            load_data <= load_ext;
                        end
                    end else if (timeout_hit) begin
                        err_q <= 1'b1;
                        if (is_load_q) begin
                            load_data <= '0;
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                DONE: begin
                    err_q <= 1'b0;
                    mis_q <= 1'b0;
                    cnt_q <= '0;
                end
                default: ;
            endcase
        end
    end

    assign dmem.dmem_read   = (state == ACCESS) && is_load_q;
    assign dmem.dmem_write  = (state == ACCESS) && !is_load_q;
    assign dmem.dmem_addr   = addr_q;
    assign dmem.dmem_wdata  = wdata_q;
    assign dmem.dmem_byteen = be_q;

    assign access_err = (state == DONE) && err_q;
    assign misaligned = (state == DONE) && mis_q;

endmodule
